multicycle_ctrl_fsm: RTL and testbench

//  Sequential control unit for the multi-cycle RV32I core. Replaces the single-cycle main decoder.

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 45 ++++
 rtl/multicycle_ctrl_fsm_op_classify.sv | 28 ++
 rtl/multicycle_ctrl_fsm.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit.
// Holds the FSM state encoding, the RV32I major opcodes the unit recognises,
// and the select codes driven onto the shared-ALU/shared-memory datapath muxes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_ALUWB    = 4'd10,
        S_BEQ      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RESSRC_ALUOUT = 2'b00;
    localparam logic [1:0] RESSRC_MEM    = 2'b01;
    localparam logic [1:0] RESSRC_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_fsm_op_classify.sv
// Combinational opcode classifier used by the DECODE transition.
// Ports:
//   i_opcode  in  7  instr[6:0]
//   o_next    out    state following DECODE for this opcode (S_TRAP if unknown)
//   o_illegal out 1  opcode is not one the core implements
module op_classify
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output state_t     o_next,
    output logic       o_illegal
);

    always_comb begin
        o_next    = S_TRAP;
        o_illegal = 1'b0;
        case (i_opcode)
            OPC_LOAD,
            OPC_STORE:  o_next = S_MEMADR;
            OPC_RTYPE:  o_next = S_EXECR;
            OPC_ITYPE:  o_next = S_EXECI;
            OPC_JAL:    o_next = S_JAL;
            OPC_BRANCH: o_next = S_BEQ;
            default:    o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Sequential control unit for the multi-cycle RV32I core.
// Walks each instruction through FETCH..WB, stalls on the memory ready
// handshake, flags illegal opcodes (sticky) and counts retired instructions.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   opcode                instr[6:0] from the instruction register
//   zero                  ALU zero flag (qualifies branches)
//   mem_ready             memory completes its access this cycle
//   PCWrite..Branch       datapath enables and mux selects
//   illegal               sticky illegal-opcode flag
//   state_o               current state code (debug)
//   instret               retired-instruction counter, wraps
module multicycle_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned TRAP_HALT     = 1,
    parameter int unsigned PERF_CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            opcode,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ALUOp,
    output logic                  RegWrite,
    output logic                  Branch,
    output logic                  illegal,
    output logic [3:0]            state_o,
    output logic [PERF_CNT_W-1:0] instret
);

    localparam logic HS_EN   = (MEM_HANDSHAKE != 0);
    localparam logic HALT_EN = (TRAP_HALT != 0);

    state_t                r_state;
    state_t                w_next;
    logic [6:0]            r_op_q;
    logic                  r_illegal;
    logic [PERF_CNT_W-1:0] r_instret;

    logic   w_ready;
    logic   w_retire;
    logic   w_pc_update;
    state_t w_cls_next;
    logic   w_cls_illegal;

    // With the handshake disabled every memory access completes in one cycle.
    assign w_ready = mem_ready | ~HS_EN;

    op_classify u_op_classify (
        .i_opcode  (opcode),
        .o_next    (w_cls_next),
        .o_illegal (w_cls_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RST;
            r_op_q    <= '0;
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op_q <= opcode;
            end
            if (r_state == S_TRAP) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_instret <= r_instret + PERF_CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_pc_update = 1'b0;
        AdrSrc      = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ResultSrc   = RESSRC_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        ALUOp       = ALUOP_ADD;
        RegWrite    = 1'b0;
        Branch      = 1'b0;

        case (r_state)
            S_RST: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                MemRead     = 1'b1;
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RESSRC_ALU;
                // IR load and PC+4 commit only once the fetch completes.
                IRWrite     = w_ready;
                w_pc_update = w_ready;
                if (w_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                w_next  = w_cls_illegal ? S_TRAP : w_cls_next;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                // Only loads and stores reach here; the latched opcode picks the access.
                w_next  = (r_op_q == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                AdrSrc  = 1'b1;
                if (w_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc = RESSRC_MEM;
                RegWrite  = 1'b1;
                w_next    = S_FETCH;
                w_retire  = 1'b1;
            end
            S_MEMWRITE: begin
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (w_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_FUNCT;
                w_next  = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
                w_next  = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA     = SRCA_OLDPC;
                ALUSrcB     = SRCB_FOUR;
                w_pc_update = 1'b1;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RESSRC_ALUOUT;
                RegWrite  = 1'b1;
                w_next    = S_FETCH;
                w_retire  = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_RS2;
                ALUOp    = ALUOP_SUB;
                Branch   = 1'b1;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP: begin
                w_next = HALT_EN ? S_TRAP : S_FETCH;
            end
            default: begin
                // Unused codes recover through RST.
                w_next = S_RST;
            end
        endcase

        PCWrite = w_pc_update | (Branch & zero);
    end

    assign illegal = r_illegal;
    assign instret = r_instret;
    assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    // Instance A: handshake on, trap halts, 32-bit counter.
    // Instance B: handshake off, one-cycle trap, 4-bit counter.
    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic [6:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       sel = 1'b0;

    logic       a_pcw, a_adr, a_mr, a_mw, a_ir, a_rw, a_br, a_ill;
    logic [1:0] a_res, a_sa, a_sb, a_op;
    logic [3:0] a_st;
    logic [31:0] a_cnt;
    logic       b_pcw, b_adr, b_mr, b_mw, b_ir, b_rw, b_br, b_ill;
    logic [1:0] b_res, b_sa, b_sb, b_op;
    logic [3:0] b_st;
    logic [3:0] b_cnt;

    multicycle_ctrl_fsm #(.MEM_HANDSHAKE(1), .TRAP_HALT(1), .PERF_CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_a), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(a_pcw), .AdrSrc(a_adr), .MemRead(a_mr), .MemWrite(a_mw), .IRWrite(a_ir),
        .ResultSrc(a_res), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ALUOp(a_op), .RegWrite(a_rw),
        .Branch(a_br), .illegal(a_ill), .state_o(a_st), .instret(a_cnt));

    multicycle_ctrl_fsm #(.MEM_HANDSHAKE(0), .TRAP_HALT(0), .PERF_CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_b), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(b_pcw), .AdrSrc(b_adr), .MemRead(b_mr), .MemWrite(b_mw), .IRWrite(b_ir),
        .ResultSrc(b_res), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ALUOp(b_op), .RegWrite(b_rw),
        .Branch(b_br), .illegal(b_ill), .state_o(b_st), .instret(b_cnt));

    always #5 clk = ~clk;

    // Output vector order: PCWrite AdrSrc MemRead MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ALUOp RegWrite Branch
    logic [14:0] act_vec;
    logic [3:0]  act_st;
    logic [31:0] act_cnt;
    logic        act_ill;
    logic [31:0] cnt_mask;
    always_comb begin
        if (sel) begin
            act_vec = {b_pcw, b_adr, b_mr, b_mw, b_ir, b_res, b_sa, b_sb, b_op, b_rw, b_br};
            act_st  = b_st;
            act_cnt = {28'd0, b_cnt};
            act_ill = b_ill;
            cnt_mask = 32'h0000_000F;
        end else begin
            act_vec = {a_pcw, a_adr, a_mr, a_mw, a_ir, a_res, a_sa, a_sb, a_op, a_rw, a_br};
            act_st  = a_st;
            act_cnt = a_cnt;
            act_ill = a_ill;
            cnt_mask = 32'hFFFF_FFFF;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut=%0d(h%0h) expected=%0d(h%0h) t=%0t sel=%0d", nm, act, act, exp, exp, $time, sel);
        end
    endtask

    // Expected datapath controls for a state, taken straight from the control table.
    function automatic logic [14:0] exp_outs(input int st, input bit rdy, input bit z);
        bit pcw, adr, mr, mw, ir, rw, br;
        int res, sa, sb, op;
        pcw = 0; adr = 0; mr = 0; mw = 0; ir = 0; rw = 0; br = 0;
        res = 0; sa = 0; sb = 0; op = 0;
        case (st)
            1:  begin mr = 1; sb = 2; res = 2; ir = rdy; pcw = rdy; end
            2:  begin sa = 1; sb = 1; end
            3:  begin sa = 2; sb = 1; end
            4:  begin mr = 1; adr = 1; end
            5:  begin res = 1; rw = 1; end
            6:  begin mw = 1; adr = 1; end
            7:  begin sa = 2; sb = 0; op = 2; end
            8:  begin sa = 2; sb = 1; op = 2; end
            9:  begin sa = 1; sb = 2; pcw = 1; end
            10: begin res = 0; rw = 1; end
            11: begin sa = 2; op = 1; br = 1; pcw = z; end
            default: ;
        endcase
        return {pcw, adr, mr, mw, ir, res[1:0], sa[1:0], sb[1:0], op[1:0], rw, br};
    endfunction

    // Model-side expectations for the current cycle.
    logic        chk_en = 1'b0;
    logic [14:0] exp_vec = '0;
    int          exp_st = 0;
    logic [31:0] exp_cnt = '0;
    logic        exp_ill = 1'b0;

    // The single per-cycle compare process.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("outputs", 32'(act_vec), 32'(exp_vec));
            chk("state_o", 32'(act_st), 32'(exp_st));
            chk("instret", act_cnt & cnt_mask, exp_cnt & cnt_mask);
            chk("illegal", 32'(act_ill), 32'(exp_ill));
        end
    end

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, JL = 7'b1101111, BR = 7'b1100011;

    function automatic bit is_legal(input logic [6:0] op);
        return op == LW || op == SW || op == RT || op == IT || op == JL || op == BR;
    endfunction

    logic obs_pcw_beq = 1'b0;

    // Builds the cycle-by-cycle expected trace of one instruction from its class
    // and stall counts, drives it and lets the compare process check it.
    // zf: -1 random zero each cycle, else forced value.
    task automatic run_instr(input logic [6:0] op, input int fst, input int mst, input int zf,
                             input int stop_after);
        int  sts[$];
        bit  rdys[$];
        bit  hs, halt, retire, z;
        int  n;
        hs   = (sel == 1'b0);
        halt = (sel == 1'b0);
        if (!hs) begin fst = 0; mst = 0; end
        for (int i = 0; i < fst; i++) begin sts.push_back(1); rdys.push_back(0); end
        sts.push_back(1); rdys.push_back(1);
        sts.push_back(2); rdys.push_back(1);
        retire = 1;
        case (op)
            LW: begin
                sts.push_back(3); rdys.push_back(1);
                for (int i = 0; i < mst; i++) begin sts.push_back(4); rdys.push_back(0); end
                sts.push_back(4); rdys.push_back(1);
                sts.push_back(5); rdys.push_back(1);
            end
            SW: begin
                sts.push_back(3); rdys.push_back(1);
                for (int i = 0; i < mst; i++) begin sts.push_back(6); rdys.push_back(0); end
                sts.push_back(6); rdys.push_back(1);
            end
            RT: begin sts.push_back(7); rdys.push_back(1); sts.push_back(10); rdys.push_back(1); end
            IT: begin sts.push_back(8); rdys.push_back(1); sts.push_back(10); rdys.push_back(1); end
            JL: begin sts.push_back(9); rdys.push_back(1); sts.push_back(10); rdys.push_back(1); end
            BR: begin sts.push_back(11); rdys.push_back(1); end
            default: begin
                retire = 0;
                n = halt ? 6 : 1;
                for (int i = 0; i < n; i++) begin sts.push_back(12); rdys.push_back(1); end
            end
        endcase
        n = (stop_after > 0 && stop_after < sts.size()) ? stop_after : sts.size();
        for (int i = 0; i < n; i++) begin
            z = (zf < 0) ? bit'($urandom_range(0, 1)) : bit'(zf);
            zero   = z;
            opcode = (sts[i] == 2) ? op : 7'($urandom);
            if (hs && (sts[i] == 1 || sts[i] == 4 || sts[i] == 6))
                mem_ready = rdys[i];
            else
                mem_ready = 1'($urandom);
            exp_vec = exp_outs(sts[i], rdys[i], z);
            exp_st  = sts[i];
            chk_en  = 1'b1;
            @(negedge clk);
            if (sts[i] == 11) obs_pcw_beq = act_vec[14];
            @(posedge clk);
            #1;
            if (sts[i] == 12) exp_ill = 1'b1;
        end
        chk_en = 1'b0;
        if (retire && n == sts.size()) exp_cnt = exp_cnt + 1;
    endtask

    // Asserts reset mid-cycle on the selected instance, checks outputs clear
    // immediately, releases and checks the RST -> FETCH step.
    task automatic do_reset;
        #2;
        if (sel) rst_b = 1'b0; else rst_a = 1'b0;
        #1;
        chk("rst_outputs", 32'(act_vec), 32'd0);
        chk("rst_state", 32'(act_st), 32'd0);
        chk("rst_instret", act_cnt, 32'd0);
        chk("rst_illegal", 32'(act_ill), 32'd0);
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
        #1;
        chk("rel_state_rst", 32'(act_st), 32'd0);
        @(posedge clk);
        #1;
        chk("rel_state_fetch", 32'(act_st), 32'd1);
        exp_cnt = '0;
        exp_ill = 1'b0;
    endtask

    function automatic logic [6:0] rand_legal();
        logic [6:0] tbl [6];
        tbl = '{LW, SW, RT, IT, JL, BR};
        return tbl[$urandom_range(0, 5)];
    endfunction

    function automatic logic [6:0] rand_illegal();
        logic [6:0] op;
        for (int i = 0; i < 8; i++) begin
            op = 7'($urandom);
            if (!is_legal(op)) return op;
        end
        return 7'b0000000;
    endfunction

    initial begin
        #1 rst_b = 1'b0;
        #1;
        // ---------------- instance A ----------------
        sel = 1'b0;
        do_reset();
        run_instr(RT, 0, 0, -1, 0);
        chk("add_instret", act_cnt, 32'd1);
        chk("add_back_fetch", 32'(act_st), 32'd1);
        run_instr(LW, 0, 3, -1, 0);
        chk("lw_stall_instret", act_cnt, 32'd2);
        run_instr(BR, 0, 0, 1, 0);
        chk("beq_taken_pcwrite", 32'(obs_pcw_beq), 32'd1);
        chk("beq_taken_instret", act_cnt, 32'd3);
        run_instr(BR, 0, 0, 0, 0);
        chk("beq_not_taken_pcwrite", 32'(obs_pcw_beq), 32'd0);
        chk("beq_not_taken_instret", act_cnt, 32'd4);
        run_instr(SW, 2, 2, -1, 0);
        run_instr(JL, 1, 0, -1, 0);
        for (int k = 0; k < 60; k++)
            run_instr(rand_legal(), $urandom_range(0, 2), $urandom_range(0, 3), -1, 0);
        // Park in MEMREAD mid-stall, then reset.
        run_instr(LW, 0, 5, -1, 5);
        chk("memread_before_reset", 32'(act_st), 32'd4);
        do_reset();
        run_instr(7'b0000000, 0, 0, -1, 0);
        chk("trap_held_state", 32'(act_st), 32'd12);
        chk("trap_held_illegal", 32'(act_ill), 32'd1);
        chk("trap_no_retire", act_cnt, 32'd0);
        do_reset();

        // ---------------- instance B ----------------
        rst_a = 1'b0;
        #7;
        @(posedge clk);
        #1;
        sel = 1'b1;
        do_reset();
        for (int k = 0; k < 15; k++) run_instr(IT, 0, 0, -1, 0);
        chk("wrap_at_15", act_cnt, 32'd15);
        run_instr(IT, 0, 0, -1, 0);
        chk("wrap_to_0", act_cnt, 32'd0);
        run_instr(LW, 3, 3, -1, 0);
        run_instr(7'b0000000, 0, 0, -1, 0);
        chk("trap_once_fetch", 32'(act_st), 32'd1);
        chk("trap_once_illegal", 32'(act_ill), 32'd1);
        chk("trap_once_instret", act_cnt, 32'd1);
        for (int k = 0; k < 50; k++) begin
            if ($urandom_range(0, 7) == 0)
                run_instr(rand_illegal(), 0, 0, -1, 0);
            else
                run_instr(rand_legal(), 0, 0, -1, 0);
        end
        chk("illegal_sticky", 32'(act_ill), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
